// File: rtl/chunked_adder_sequencer.sv
// -----------------------------------------------------------------------------
// chunked_adder_sequencer
//
// Purpose:
//   Adds two WIDTH-bit operands serially, four bits per cycle, through a single
//   shared 4-bit carry_bypass_adder. It sits between an ALU issue stage (start
//   handshake) and writeback (result handshake), so a wide add reuses one small
//   adder instead of needing a full-width one.
//
// Ports:
//   clk          in   1      sole clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   start_valid  in   1      a, b, c_in are valid
//   start_ready  out  1      block can accept an operation (high in IDLE)
//   a, b         in   WIDTH  operands
//   c_in         in   1      carry into bit 0
//   res_valid    out  1      sum, c_out, ovf are valid (high in DONE)
//   res_ready    in   1      consumer accepts the result
//   sum          out  WIDTH  a + b + c_in, low WIDTH bits
//   c_out        out  1      carry out of bit WIDTH-1
//   ovf          out  1      two's-complement overflow
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of 4 and >= 4.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// carry_bypass_adder
//
// Purpose:
//   4-bit adder whose carry out skips the ripple chain when every bit
//   propagates. In that case the carry out simply equals the carry in.
//
// Ports:
//   a, b    in   4  operand nibbles
//   c_in    in   1  carry in
//   sum     out  4  a + b + c_in, low 4 bits
//   c_out   out  1  carry out
// -----------------------------------------------------------------------------
module carry_bypass_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] prop;
  logic [3:0] gen;
  logic       ripple;

  always_comb begin
    prop   = a ^ b;
    gen    = a & b;
    sum    = '0;
    ripple = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i] = prop[i] ^ ripple;
      ripple = gen[i] | (prop[i] & ripple);
    end
    // When every bit propagates, the ripple result equals c_in anyway.
    // Taking the bypass path shortens the critical path through the block.
    c_out = (&prop) ? c_in : ripple;
  end

endmodule

module chunked_adder_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CHUNKS = WIDTH / 4;
  // Keep the counter at least 1 bit wide so that WIDTH=4 still elaborates.
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       add_sum;
  logic             add_c_out;

  // The shared nibble adder always sees the low nibble of the shift registers.
  carry_bypass_adder u_adder (
    .a     (a_sh_q[3:0]),
    .b     (b_sh_q[3:0]),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_c_out)
  );

  // NOTE: every variable gets its hold value first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d = a_sh_q >> 4;
        b_sh_d = b_sh_q >> 4;
        // New nibbles enter at the top, so after CHUNKS passes the first
        // nibble computed has reached bits [3:0].
        sum_d                = sum_q >> 4;
        sum_d[WIDTH-1 -: 4]  = add_sum;
        carry_d              = add_c_out;
        cnt_d                = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          c_out_d = add_c_out;
          // The carry into the MSB is recovered from the MSB inputs and the
          // MSB sum bit of this final nibble: a ^ b ^ sum.
          ovf_d   = add_c_out ^ (a_sh_q[3] ^ b_sh_q[3] ^ add_sum[3]);
          state_d = DONE;
        end
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // is cleared by reset, so an aborted operation leaves no partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign c_out       = c_out_q;
  assign ovf         = ovf_q;

endmodule
